adc_seq_ctrl: RTL

- Channel-scan sequencer for the 10-bit SAR ADC macro (EN/START/EOC/D handshake).
- Walks an enabled-channel mask and drives the analog input mux select.
- Per channel: settles the mux, issues a START pulse, waits for the EOC low→high cycle, then publishes the 10-bit result with its channel tag.
- Sits between the SoC config/status registers and the ADC macro; single-shot or continuous scan.

---
 rtl/adc_seq_ctrl_pkg.sv | 28 ++
 rtl/adc_seq_ctrl_if.sv | 15 +
 rtl/adc_seq_ctrl_prio.sv | 25 ++
 rtl/adc_seq_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/adc_seq_ctrl_pkg.sv
// Shared types, constants and helpers for the ADC channel-scan sequencer.
// Optional feature macro: ADC_SEQ_AVG_EN (4x per-channel averaging).
package adc_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    START,
    WAIT_LO,
    WAIT_HI,
    STORE
  } state_t;

  localparam int ADC_DW = 10;
  localparam int AVG_N  = 4;
  localparam int MAX_CH = 8;

  // Index of the lowest set bit strictly above cur (cur = -1 searches from bit 0); -1 if none.
  function automatic int next_set_bit(input logic [MAX_CH-1:0] mask, input int cur);
    int idx;
    idx = -1;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (mask[i] && (i > cur)) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/adc_seq_ctrl_if.sv
// Handshake bundle between the sequencer (master) and the SAR ADC macro (slave).
interface adc_seq_ctrl_if import adc_seq_pkg::*; #(
  parameter int NCH = 4
) ();

  logic                    en;
  logic                    start;
  logic                    eoc;
  logic [ADC_DW-1:0]       d;
  logic [$clog2(NCH)-1:0]  sel;

  modport master (output en, output start, output sel, input eoc, input d);
  modport slave  (input en, input start, input sel, output eoc, output d);

endinterface

// File: rtl/adc_seq_ctrl_prio.sv
// Combinational set-bit finder: lowest set bit, or the next set bit above a given index.
module adc_seq_prio import adc_seq_pkg::*; #(
  parameter int NCH = 4
) (
  input  logic [NCH-1:0]          i_mask,
  input  logic [$clog2(NCH)-1:0]  i_cur,
  input  logic                    i_from_start,
  output logic [$clog2(NCH)-1:0]  o_idx,
  output logic                    o_found
);

  localparam int SW = $clog2(NCH);

  int w_cur;
  int w_pos;

  // Search the mask from bit 0 or from just above the current channel.
  always_comb begin
    w_cur   = i_from_start ? -1 : int'(i_cur);
    w_pos   = next_set_bit(MAX_CH'(i_mask), w_cur);
    o_found = (w_pos >= 0);
    o_idx   = o_found ? SW'(w_pos) : '0;
  end

endmodule

// File: rtl/adc_seq_ctrl.sv
// Channel-scan sequencer for the 10-bit SAR ADC: settle mux, pulse START,
// wait for the EOC low->high cycle, publish the tagged result.
// Optional feature macro: ADC_SEQ_AVG_EN (4 conversions per channel, averaged).
module adc_seq_ctrl import adc_seq_pkg::*; #(
  parameter int NCH        = 4,
  parameter int SETTLE_CYC = 4,
  parameter int START_CYC  = 3,
  parameter int TMO_CYC    = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_cfg_en,
  input  logic                    i_cfg_cont,
  input  logic [NCH-1:0]          i_cfg_mask,
  input  logic                    i_trig,
  adc_seq_ctrl_if.master          adc,
  output logic [ADC_DW-1:0]       o_res_data,
  output logic [$clog2(NCH)-1:0]  o_res_ch,
  output logic                    o_res_valid,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_tmo_err
);

  localparam int SW = $clog2(NCH);
  localparam int CW = 8;
  localparam int TW = $clog2(TMO_CYC + 1);

  state_t            r_state, w_state_next;
  logic [NCH-1:0]    r_scan;
  logic [SW-1:0]     r_sel;
  logic [CW-1:0]     r_cnt;
  logic [TW-1:0]     r_tmo;
  logic              r_adc_en;
  logic              r_tmo_err;
  logic [ADC_DW-1:0] r_res_data;
  logic [SW-1:0]     r_res_ch;

  logic [SW-1:0] w_lo_idx, w_nx_idx;
  logic          w_lo_found, w_nx_found;
  logic          w_conv_phase;
  logic          w_accept, w_advance, w_reload, w_finish;
  logic          w_capture, w_again, w_tmo_hit, w_abort;

  adc_seq_prio #(.NCH(NCH)) u_prio_lo (
    .i_mask       (i_cfg_mask),
    .i_cur        (r_sel),
    .i_from_start (1'b1),
    .o_idx        (w_lo_idx),
    .o_found      (w_lo_found)
  );

  adc_seq_prio #(.NCH(NCH)) u_prio_nx (
    .i_mask       (r_scan),
    .i_cur        (r_sel),
    .i_from_start (1'b0),
    .o_idx        (w_nx_idx),
    .o_found      (w_nx_found)
  );

  assign w_conv_phase = (r_state inside {START, WAIT_LO, WAIT_HI});

`ifdef ADC_SEQ_AVG_EN
  localparam int AW = $clog2(AVG_N);
  logic [11:0]   r_sum;
  logic [AW-1:0] r_avg;
  logic [11:0]   w_sum_next;

  assign w_sum_next = r_sum + 12'(adc.d);

  // Accumulate back-to-back samples of one channel; cleared whenever no conversion is running.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum <= '0;
      r_avg <= '0;
    end else if (w_again) begin
      r_sum <= w_sum_next;
      r_avg <= r_avg + 1'b1;
    end else if (r_state inside {IDLE, SETTLE, STORE}) begin
      r_sum <= '0;
      r_avg <= '0;
    end
  end
`endif

  // Next-state and control decode; disable beats timeout, timeout beats normal flow.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_advance    = 1'b0;
    w_reload     = 1'b0;
    w_finish     = 1'b0;
    w_capture    = 1'b0;
    w_again      = 1'b0;
    w_tmo_hit    = 1'b0;
    w_abort      = 1'b0;
    if ((r_state != IDLE) && !i_cfg_en) begin
      w_abort      = 1'b1;
      w_state_next = IDLE;
    end else if (w_conv_phase && (r_tmo == TW'(TMO_CYC - 1))) begin
      w_tmo_hit    = 1'b1;
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_trig && i_cfg_en && w_lo_found) begin
            w_accept     = 1'b1;
            w_state_next = SETTLE;
          end
        end
        SETTLE: if (r_cnt == CW'(SETTLE_CYC - 1)) w_state_next = START;
        START:  if (r_cnt == CW'(START_CYC - 1))  w_state_next = WAIT_LO;
        WAIT_LO: if (!adc.eoc) w_state_next = WAIT_HI;
        WAIT_HI: begin
          if (adc.eoc) begin
`ifdef ADC_SEQ_AVG_EN
            if (r_avg == AW'(AVG_N - 1)) begin
              w_capture    = 1'b1;
              w_state_next = STORE;
            end else begin
              w_again      = 1'b1;
              w_state_next = START;
            end
`else
            w_capture    = 1'b1;
            w_state_next = STORE;
`endif
          end
        end
        STORE: begin
          if (w_nx_found) begin
            w_advance    = 1'b1;
            w_state_next = SETTLE;
          end else if (i_cfg_cont && w_lo_found) begin
            w_reload     = 1'b1;
            w_state_next = SETTLE;
          end else begin
            w_finish     = 1'b1;
            w_state_next = IDLE;
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Settle/start phase counter restarts on every state change; timeout counter on each START entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_tmo <= '0;
    end else begin
      if (w_state_next != r_state)                  r_cnt <= '0;
      else if (r_state inside {SETTLE, START})      r_cnt <= r_cnt + 1'b1;
      if ((w_state_next == START) && (r_state != START)) r_tmo <= '0;
      else if (w_conv_phase)                        r_tmo <= r_tmo + 1'b1;
    end
  end

  // Scan mask, mux select, error flag and published result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_adc_en   <= 1'b0;
      r_scan     <= '0;
      r_sel      <= '0;
      r_tmo_err  <= 1'b0;
      r_res_data <= '0;
      r_res_ch   <= '0;
    end else begin
      r_adc_en <= i_cfg_en;
      if (w_accept || w_reload) begin
        r_scan <= i_cfg_mask;
        r_sel  <= w_lo_idx;
      end else if (w_advance) begin
        r_scan <= r_scan & ~(NCH'(1) << r_sel);
        r_sel  <= w_nx_idx;
      end else if (w_finish || w_abort || w_tmo_hit) begin
        r_scan <= '0;
      end
      if (w_accept)       r_tmo_err <= 1'b0;
      else if (w_tmo_hit) r_tmo_err <= 1'b1;
      if (w_capture) begin
`ifdef ADC_SEQ_AVG_EN
        r_res_data <= w_sum_next[11:2];
`else
        r_res_data <= adc.d;
`endif
        r_res_ch   <= r_sel;
      end
    end
  end

  assign adc.en      = r_adc_en;
  assign adc.start   = (r_state == START);
  assign adc.sel     = r_sel;
  assign o_res_data  = r_res_data;
  assign o_res_ch    = r_res_ch;
  assign o_res_valid = (r_state == STORE);
  assign o_busy      = (r_state != IDLE);
  assign o_done      = w_finish;
  assign o_tmo_err   = r_tmo_err;

endmodule
